// File: rtl/gpu_instruction_dispatch_pkg.sv
// Shared GPU definitions: screen geometry, opcodes, engine indices and the
// dispatcher state type.
package gpu_instruction_dispatch_pkg;

  localparam int WIDTH   = 10;
  localparam int HEIGHT  = 9;
  localparam int CHANNEL = 8;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LINE   = 4'd1,
    OP_RECT   = 4'd2,
    OP_CIRCLE = 4'd3,
    OP_SWAP   = 4'd4
  } opcode_e;

  localparam logic [1:0] ENG_LINE   = 2'd0;
  localparam logic [1:0] ENG_RECT   = 2'd1;
  localparam logic [1:0] ENG_CIRCLE = 2'd2;
  localparam logic [1:0] ENG_SWAP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  // Engine slot for an opcode; only meaningful for LINE..SWAP.
  function automatic logic [1:0] engine_of(input logic [3:0] op);
    case (op)
      OP_RECT:   return ENG_RECT;
      OP_CIRCLE: return ENG_CIRCLE;
      OP_SWAP:   return ENG_SWAP;
      default:   return ENG_LINE;
    endcase
  endfunction

endpackage

// File: rtl/gpu_instruction_dispatch_watchdog.sv
// Engine watchdog: counts enabled cycles since clear; expired flags the cycle
// whose increment brings the count to all-ones (2^WDOG_BITS-1 enabled cycles).
module gpu_watchdog_counter #(
  parameter int WDOG_BITS = 20
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WDOG_BITS-1:0] ONE  = WDOG_BITS'(1);
  localparam logic [WDOG_BITS-1:0] LAST = {{(WDOG_BITS-1){1'b1}}, 1'b0};

  logic [WDOG_BITS-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + ONE;
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/gpu_instruction_dispatch.sv
// Fetches drawing instructions from the FIFO and issues them one at a time to the
// line/rect/circle/swap engines; start is two cycles after pop, held while busy.
module gpu_instruction_dispatch
  import gpu_instruction_dispatch_pkg::*;
#(
  parameter int WDOG_BITS = 20
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               fifo_empty_i,
  input  logic [3:0]         opcode_i,
  input  logic [WIDTH-1:0]   x1_i,
  input  logic [HEIGHT-1:0]  y1_i,
  input  logic [WIDTH-1:0]   x2_i,
  input  logic [HEIGHT-1:0]  y2_i,
  input  logic [WIDTH-1:0]   rad_i,
  input  logic [CHANNEL-1:0] r_i,
  input  logic [CHANNEL-1:0] g_i,
  input  logic [CHANNEL-1:0] b_i,
  input  logic [2:0]         oct_i,
  output logic               pop_instruction_o,
  input  logic               halt_i,
  input  logic [3:0]         engine_busy_i,
  input  logic [3:0]         engine_done_i,
  output logic [3:0]         engine_start_o,
  output logic [WIDTH-1:0]   x1_o,
  output logic [HEIGHT-1:0]  y1_o,
  output logic [WIDTH-1:0]   x2_o,
  output logic [HEIGHT-1:0]  y2_o,
  output logic [WIDTH-1:0]   rad_o,
  output logic [CHANNEL-1:0] r_o,
  output logic [CHANNEL-1:0] g_o,
  output logic [CHANNEL-1:0] b_o,
  output logic [2:0]         oct_o,
  output logic               idle_o,
  output logic               err_illegal_o,
  output logic               err_timeout_o,
  input  logic               err_clr_i,
  output logic               irq_o,
  output logic [15:0]        instr_count_o
);

  state_e     state;
  logic [3:0] opcode_q;
  logic [1:0] target;
  logic       fetch;
  logic       start;
  logic       done_hit;
  logic       wdog_expired;
  logic       timeout;
  logic       illegal;

  assign target   = engine_of(opcode_q);
  // Gated by n_rst so the FIFO is never popped while reset is held.
  assign fetch    = n_rst && (state == ST_IDLE) && !fifo_empty_i && !halt_i;
  assign start    = (state == ST_ISSUE) && !engine_busy_i[target];
  assign done_hit = (state == ST_WAIT) && engine_done_i[target];
  assign timeout  = wdog_expired && !done_hit;
  assign illegal  = (state == ST_DECODE) && (opcode_q > OP_SWAP);

  assign pop_instruction_o = fetch;
  assign idle_o            = (state == ST_IDLE);

  always_comb begin
    engine_start_o         = '0;
    engine_start_o[target] = start;
  end

  gpu_watchdog_counter #(
    .WDOG_BITS(WDOG_BITS)
  ) u_watchdog (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (start),
    .enable (state == ST_WAIT),
    .expired(wdog_expired)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= ST_IDLE;
      opcode_q      <= '0;
      x1_o          <= '0;
      y1_o          <= '0;
      x2_o          <= '0;
      y2_o          <= '0;
      rad_o         <= '0;
      r_o           <= '0;
      g_o           <= '0;
      b_o           <= '0;
      oct_o         <= '0;
      err_illegal_o <= 1'b0;
      err_timeout_o <= 1'b0;
      irq_o         <= 1'b0;
      instr_count_o <= '0;
    end else begin
      irq_o <= (illegal && !err_illegal_o) || (timeout && !err_timeout_o);

      // A new error outranks a simultaneous clear.
      if (illegal) begin
        err_illegal_o <= 1'b1;
      end else if (err_clr_i) begin
        err_illegal_o <= 1'b0;
      end
      if (timeout) begin
        err_timeout_o <= 1'b1;
      end else if (err_clr_i) begin
        err_timeout_o <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (fetch) begin
            state    <= ST_DECODE;
            opcode_q <= opcode_i;
            x1_o     <= x1_i;
            y1_o     <= y1_i;
            x2_o     <= x2_i;
            y2_o     <= y2_i;
            rad_o    <= rad_i;
            r_o      <= r_i;
            g_o      <= g_i;
            b_o      <= b_i;
            oct_o    <= oct_i;
          end
        end
        ST_DECODE: begin
          state <= ((opcode_q == OP_NOP) || illegal) ? ST_IDLE : ST_ISSUE;
        end
        ST_ISSUE: begin
          if (start) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_hit) begin
            instr_count_o <= instr_count_o + 16'd1;
            state         <= ST_IDLE;
          end else if (timeout) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
